// File: rtl/ms_fpu_mul_div.sv
// Shared iterative unsigned multiplier/divider for the FPU mantissa path.
// Multiply is radix-2 shift-add: one multiplier bit per enabled edge, 32 iterations.
// Divide is radix-2 restoring division of {D,28'h0} by S, MSB first, 60 iterations.
// A new start while busy aborts the running operation and restarts with the new operands.
module ms_fpu_mul_div (
   input  logic        AClkH,
   input  logic        AResetH,
   input  logic        AClkHEn,
   input  logic [1:0]  AStart,
   input  logic [31:0] ADataS,
   input  logic [31:0] ADataD,
   output logic [31:0] ADataR,
   output logic [31:0] ADataH,
   output logic        AWrEn,
   output logic        ABusy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } stateT;

   stateT       state;
   logic [31:0] opS;
   logic [63:0] mulAcc;
   logic [31:0] divRem;
   logic [59:0] divQuo;
   logic [5:0]  iterCnt;

   logic [32:0] mulSum;
   logic [63:0] mulNext;
   logic [32:0] remShift;
   logic [31:0] remDiff;
   logic        remGe;
   logic [31:0] remNext;
   logic [59:0] quoNext;

   // One shift-add step: the upper half accumulates S when the current multiplier
   // bit is set, then the whole product register shifts right, retiring that bit.
   always_comb begin
      mulSum  = {1'b0, mulAcc[63:32]} + (mulAcc[0] ? {1'b0, opS} : 33'd0);
      mulNext = {mulSum, mulAcc[31:1]};
   end

   // One restoring-division step: shift the next dividend bit into the remainder,
   // subtract the divisor if it fits, and shift the resulting quotient bit in at the
   // bottom of the dividend/quotient register. The remainder stays below S, so 32
   // stored bits are enough and the 32-bit difference is exact whenever it is kept.
   always_comb begin
      remShift = {divRem, divQuo[59]};
      remGe    = (remShift >= {1'b0, opS});
      remDiff  = remShift[31:0] - opS;
      remNext  = remGe ? remDiff : remShift[31:0];
      quoNext  = {divQuo[58:0], remGe};
   end

   // Control, datapath and result registers; everything advances only on enabled edges.
   always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH) begin
         state   <= IDLE;
         opS     <= 32'h0;
         mulAcc  <= 64'h0;
         divRem  <= 32'h0;
         divQuo  <= 60'h0;
         iterCnt <= 6'd0;
         ADataR  <= 32'h0;
         ADataH  <= 32'h0;
         AWrEn   <= 1'b0;
         ABusy   <= 1'b0;
      end else if (AClkHEn) begin
         if (AStart != 2'b00) begin
            opS   <= ADataS;
            AWrEn <= 1'b0;
            ABusy <= 1'b1;
            if (AStart[1]) begin
               state   <= DIV;
               divRem  <= 32'h0;
               divQuo  <= {ADataD, 28'h0};
               iterCnt <= 6'd59;
            end else begin
               state   <= MUL;
               mulAcc  <= {32'h0, ADataD};
               iterCnt <= 6'd31;
            end
         end else begin
            AWrEn <= 1'b0;
            case (state)
               MUL: begin
                  mulAcc <= mulNext;
                  if (iterCnt == 6'd0) begin
                     state  <= IDLE;
                     ABusy  <= 1'b0;
                     AWrEn  <= 1'b1;
                     ADataR <= mulNext[50:19];
                     ADataH <= {13'h0, mulNext[18:0]};
                  end else begin
                     iterCnt <= iterCnt - 6'd1;
                  end
               end
               DIV: begin
                  divRem <= remNext;
                  divQuo <= quoNext;
                  if (iterCnt == 6'd0) begin
                     state <= IDLE;
                     ABusy <= 1'b0;
                     AWrEn <= 1'b1;
                     if (opS == 32'h0) begin
                        ADataR <= 32'hFFFF_FFFF;
                        ADataH <= 32'h0;
                     end else begin
                        ADataR <= quoNext[31:0];
                        ADataH <= remNext;
                     end
                  end else begin
                     iterCnt <= iterCnt - 6'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ms_fpu_mul_div.sv
// Testbench for ms_fpu_mul_div: directed vectors, a transaction-level reference
// model compared every cycle, and literal result checks for the known vectors.
module tb_ms_fpu_mul_div;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b1;
   logic [1:0]  start = 2'b00;
   logic [31:0] s = 32'h0;
   logic [31:0] d = 32'h0;
   logic [31:0] dataR;
   logic [31:0] dataH;
   logic        wrEn;
   logic        busy;

   logic        mBusy = 1'b0;
   logic        mWrEn = 1'b0;
   logic [31:0] mR = 32'h0;
   logic [31:0] mH = 32'h0;
   logic [31:0] mS = 32'h0;
   logic [31:0] mD = 32'h0;
   logic        mIsDiv = 1'b0;
   int          mLeft = 0;

   int checks = 0;
   int errors = 0;
   bit randEn = 1'b0;
   bit compareOn = 1'b0;
   int wrEnSeen = 0;
   int edges;

   ms_fpu_mul_div dut (
      .AClkH   (clock),
      .AResetH (reset),
      .AClkHEn (en),
      .AStart  (start),
      .ADataS  (s),
      .ADataD  (d),
      .ADataR  (dataR),
      .ADataH  (dataH),
      .AWrEn   (wrEn),
      .ABusy   (busy)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Arithmetic result {R,H} of an operation, straight from the definitions.
   function automatic logic [63:0] expResult(input logic isDiv, input logic [31:0] sv,
                                             input logic [31:0] dv);
      logic [63:0] p;
      logic [63:0] n;
      if (!isDiv) begin
         p = {32'h0, sv} * {32'h0, dv};
         return {32'(p >> 19), 13'h0, 19'(p)};
      end
      if (sv == 32'h0) return {32'hFFFF_FFFF, 32'h0};
      n = {4'h0, dv, 28'h0};
      return {32'(n / {32'h0, sv}), 32'(n % {32'h0, sv})};
   endfunction

   function automatic bit nextEn();
      if (!randEn) return 1'b1;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: an operation in flight completes after its count of enabled
   // edges; a new start replaces it, the valid pulse lasts until the next enabled edge.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mBusy <= 1'b0;
         mWrEn <= 1'b0;
         mR    <= 32'h0;
         mH    <= 32'h0;
         mLeft <= 0;
      end else if (en) begin
         if (start != 2'b00) begin
            mBusy  <= 1'b1;
            mWrEn  <= 1'b0;
            mIsDiv <= start[1];
            mS     <= s;
            mD     <= d;
            mLeft  <= start[1] ? 60 : 32;
         end else if (mBusy) begin
            if (mLeft == 1) begin
               mBusy      <= 1'b0;
               mWrEn      <= 1'b1;
               {mR, mH}   <= expResult(mIsDiv, mS, mD);
            end else begin
               mLeft <= mLeft - 1;
               mWrEn <= 1'b0;
            end
         end else begin
            mWrEn <= 1'b0;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clock) begin
      if (compareOn) begin
         checkOutput("AWrEn", {31'h0, wrEn}, {31'h0, mWrEn});
         checkOutput("ABusy", {31'h0, busy}, {31'h0, mBusy});
         checkOutput("ADataR", dataR, mR);
         checkOutput("ADataH", dataH, mH);
         if (wrEn) wrEnSeen++;
      end
   end

   task automatic applyStimulus(input logic [1:0] st, input logic [31:0] sv,
                                input logic [31:0] dv);
      en    = 1'b1;
      start = st;
      s     = sv;
      d     = dv;
      @(posedge clock);
      @(negedge clock);
      start = 2'b00;
      en    = nextEn();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
         en = nextEn();
      end
   endtask

   task automatic waitDone(input int limit, output int edgeCount);
      int iter;
      edgeCount = 0;
      iter = 0;
      while (wrEn !== 1'b1 && iter < limit) begin
         @(posedge clock);
         if (en) edgeCount++;
         @(negedge clock);
         en = nextEn();
         iter++;
      end
      if (wrEn !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout: AWrEn=%b after %0d cycles, required 1", wrEn, limit);
      end
   endtask

   task automatic runOp(input string name, input logic [1:0] st, input logic [31:0] sv,
                        input logic [31:0] dv, input int expEdges);
      applyStimulus(st, sv, dv);
      waitDone(600, edges);
      checkOutput({name, "_edges"}, 32'(edges), 32'(expEdges));
   endtask

   initial begin
      #1 reset = 1'b1;
      compareOn = 1'b1;
      #1;
      checkOutput("rst_R", dataR, 32'h0);
      checkOutput("rst_H", dataH, 32'h0);
      checkOutput("rst_WrEn", {31'h0, wrEn}, 32'h0);
      checkOutput("rst_Busy", {31'h0, busy}, 32'h0);
      #11 reset = 1'b0;
      @(negedge clock);
      idle(3);

      runOp("mul800k", 2'b01, 32'h0080_0000, 32'h0080_0000, 32);
      checkOutput("mul800k_R", dataR, 32'h0800_0000);
      checkOutput("mul800k_H", dataH, 32'h0000_0000);

      runOp("mulFFFFFF", 2'b01, 32'h00FF_FFFF, 32'h00FF_FFFF, 32);
      checkOutput("mulFFFFFF_R", dataR, 32'h1FFF_FFC0);
      checkOutput("mulFFFFFF_H", dataH, 32'h0000_0001);

      runOp("divC0", 2'b10, 32'h00C0_0000, 32'h0080_0000, 60);
      checkOutput("divC0_R", dataR, 32'h0AAA_AAAA);
      checkOutput("divC0_H", dataH, 32'h0080_0000);
      idle(2);

      runOp("divBoth", 2'b11, 32'h0080_0000, 32'h0080_0000, 60);
      checkOutput("divBoth_R", dataR, 32'h1000_0000);
      checkOutput("divBoth_H", dataH, 32'h0000_0000);

      runOp("divZero", 2'b10, 32'h0000_0000, 32'h0012_3456, 60);
      checkOutput("divZero_R", dataR, 32'hFFFF_FFFF);
      checkOutput("divZero_H", dataH, 32'h0000_0000);
      idle(3);

      applyStimulus(2'b01, 32'h0000_1234, 32'h0000_5678);
      idle(9);
      runOp("restart", 2'b10, 32'h0080_0000, 32'h0080_0000, 60);
      checkOutput("restart_R", dataR, 32'h1000_0000);
      idle(2);

      randEn = 1'b1;
      runOp("mulGaps", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32);
      idle(6);
      runOp("divGaps", 2'b10, 32'h0000_0007, 32'hFFFF_FFFF, 60);
      idle(6);
      randEn = 1'b0;
      en = 1'b1;
      idle(2);

      applyStimulus(2'b10, 32'h0000_0003, 32'h0000_1000);
      idle(20);
      #2 reset = 1'b1;
      #1;
      checkOutput("midRst_R", dataR, 32'h0);
      checkOutput("midRst_H", dataH, 32'h0);
      checkOutput("midRst_WrEn", {31'h0, wrEn}, 32'h0);
      checkOutput("midRst_Busy", {31'h0, busy}, 32'h0);
      #1 reset = 1'b0;
      @(negedge clock);
      wrEnSeen = 0;
      idle(80);
      checkOutput("noWrEnAfterRst", 32'(wrEnSeen), 32'h0);

      #2 reset = 1'b1;
      #1 reset = 1'b0;
      @(negedge clock);
      runOp("postRst", 2'b01, 32'h00FF_FFFF, 32'h00FF_FFFF, 32);
      checkOutput("postRst_R", dataR, 32'h1FFF_FFC0);
      checkOutput("postRst_H", dataH, 32'h0000_0001);
      idle(3);

      compareOn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
